// File: rtl/ripple_count_capture.sv
// Captures a settled count from an asynchronous ripple counter.
// Tracks wrap-arounds and times out requests that never settle.
module ripple_count_capture #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 8,
  parameter int WRAP_W    = 8,
  localparam int TW = (MAX_TRIES > 2) ? $clog2(MAX_TRIES) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              sample_req,
  output logic [WIDTH-1:0]  count_out,
  output logic              count_valid,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              busy,
  output logic              err
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  s1_q, s2_q, s3_q;
  logic [WIDTH-1:0]  cnt_q, last_q;
  logic [WRAP_W-1:0] wrap_q;
  logic [TW-1:0]     tries_q;
  logic              valid_q, tc_q, err_q;
  logic              stable;
  logic              wrapped;

  // Two settled samples in a row mean the ripple has finished.
  assign stable  = (s2_q == s3_q);
  assign wrapped = (s2_q < last_q);

  // Resample the ripple bits into clk domain in every state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= q_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Request FSM with registered capture results and pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      wrap_q  <= '0;
      tries_q <= '0;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_req) begin
            state_q <= WAIT;
            tries_q <= '0;
          end
        end
        WAIT: begin
          if (stable) begin
            cnt_q   <= s2_q;
            last_q  <= s2_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
            if (wrapped) begin
              tc_q   <= 1'b1;
              wrap_q <= wrap_q + WRAP_W'(1);
            end
          end else if (tries_q == LAST_TRY) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tries_q <= tries_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_out   = cnt_q;
  assign count_valid = valid_q;
  assign tc_pulse    = tc_q;
  assign wrap_cnt    = wrap_q;
  assign busy        = (state_q == WAIT);
  assign err         = err_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture.
// Expected captures are queued by stimulus, checked by a monitor.
module tb_ripple_count_capture;

  logic       clk;
  logic       clr;
  logic [3:0] q_in;
  logic       sample_req;
  logic [3:0] count_out;
  logic       count_valid;
  logic       tc_pulse;
  logic [7:0] wrap_cnt;
  logic       busy;
  logic       err;

  ripple_count_capture #(
    .WIDTH(4),
    .MAX_TRIES(8),
    .WRAP_W(8)
  ) dut (
    .clk(clk),
    .clr(clr),
    .q_in(q_in),
    .sample_req(sample_req),
    .count_out(count_out),
    .count_valid(count_valid),
    .tc_pulse(tc_pulse),
    .wrap_cnt(wrap_cnt),
    .busy(busy),
    .err(err)
  );

  typedef struct {
    bit          is_err;
    logic [3:0]  cnt;
    bit          tc;
    logic [7:0]  wrap;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned edge_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every output event pops one expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!clr && (count_valid || err || tc_pulse)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out edge=%0d valid=%b err=%b tc=%b cnt=%h",
                 edge_n, count_valid, err, tc_pulse, count_out);
      end else begin
        e = sb.pop_front();
        if (err !== e.is_err || count_valid !== !e.is_err ||
            count_out !== e.cnt || tc_pulse !== e.tc ||
            wrap_cnt !== e.wrap || edge_n != e.at) begin
          n_bad++;
          $display("FAIL capture got: edge=%0d err=%b valid=%b cnt=%h tc=%b wrap=%0d want: edge=%0d err=%b cnt=%h tc=%b wrap=%0d",
                   edge_n, err, count_valid, count_out, tc_pulse, wrap_cnt,
                   e.at, e.is_err, e.cnt, e.tc, e.wrap);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic push(input bit is_e, input logic [3:0] c, input bit tc,
                      input logic [7:0] w, input int unsigned at);
    exp_t e;
    e.is_err = is_e;
    e.cnt    = c;
    e.tc     = tc;
    e.wrap   = w;
    e.at     = at;
    sb.push_back(e);
  endtask

  // Settle q_in, then issue a one-cycle request expected to capture v.
  task automatic cap(input logic [3:0] v, input bit tc, input logic [7:0] w);
    @(negedge clk);
    q_in = v;
    repeat (3) @(negedge clk);
    sample_req = 1'b1;
    push(1'b0, v, tc, w, edge_n + 2);
    @(negedge clk);
    sample_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int         idx;
    int         prev_idx;
    logic [3:0] v;
    logic [7:0] w;
    bit         tcx;
    int unsigned k0;

    clr        = 1'b1;
    q_in       = 4'h0;
    sample_req = 1'b0;
    #1;
    chk("rst_count", int'(count_out), 0);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // static capture, first capture vs last_cap=0: no wrap
    cap(4'h5, 1'b0, 8'd0);

    // settling ripple 7 -> 6 -> 4 -> 0 -> 8
    @(negedge clk);
    q_in = 4'h7;
    repeat (4) @(negedge clk);
    q_in = 4'h6;
    @(negedge clk);
    q_in = 4'h4;
    sample_req = 1'b1;
    push(1'b0, 4'h8, 1'b0, 8'd0, edge_n + 1 + 5);
    @(negedge clk);
    q_in = 4'h0;
    sample_req = 1'b0;
    @(negedge clk);
    q_in = 4'h8;
    repeat (2) @(negedge clk);
    chk("ripple_busy", int'(busy), 1);
    chk("ripple_no_early", int'(count_valid), 0);
    repeat (6) @(negedge clk);

    // wrap detection and equal-value capture
    cap(4'hE, 1'b0, 8'd0);
    cap(4'hF, 1'b0, 8'd0);
    cap(4'h1, 1'b1, 8'd1);
    cap(4'h1, 1'b0, 8'd1);

    // timeout with q_in toggling every cycle
    q_in = 4'h3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      q_in = (q_in == 4'h3) ? 4'hC : 4'h3;
      if (i == 4) begin
        sample_req = 1'b1;
        push(1'b1, 4'h1, 1'b0, 8'd1, edge_n + 1 + 8);
      end
      if (i == 5) sample_req = 1'b0;
    end
    chk("timeout_count_hold", int'(count_out), 1);
    repeat (3) @(negedge clk);

    // asynchronous reset mid-simulation, no clock edge needed
    @(negedge clk);
    q_in = 4'hA;
    sample_req = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    chk("arst_count", int'(count_out), 0);
    chk("arst_wrap", int'(wrap_cnt), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    sample_req = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    cap(4'hA, 1'b0, 8'd0);

    // continuous request; q_in steps before edges 11, 21, ...
    @(negedge clk);
    k0 = edge_n + 1;
    prev_idx = 0;
    w = 8'd0;
    for (int r = 2; r <= 232; r += 2) begin
      idx = (r < 3) ? 0 : (r - 3) / 10;
      v = 4'hA + 4'(idx);
      tcx = (idx != prev_idx) && (v == 4'h0);
      if (tcx) w = w + 8'd1;
      push(1'b0, v, tcx, w, k0 + r - 1);
      prev_idx = idx;
    end
    sample_req = 1'b1;
    for (int r = 1; r <= 232; r++) begin
      if (r > 1 && (r % 10) == 1) q_in = q_in + 4'd1;
      @(negedge clk);
    end
    sample_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("cont_wrap_final", int'(wrap_cnt), 2);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_outputs pending=%0d want=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Downstream consumer of the asynchronous D-flip-flop ripple counter.
- Resamples the counter's Q bits into the system clock domain and waits until the value is stable, since ripple bits settle at different times.
- Returns a clean count on request, tracks counter wrap-arounds, and flags requests that never see a stable value.

Parameters:
- WIDTH, 4, number of ripple counter bits sampled.
- MAX_TRIES, 8, number of WAIT cycles allowed before a request is abandoned with err; must be at least 2.
- WRAP_W, 8, width of the wrap-around counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- q_in  input  WIDTH  raw Q outputs of the ripple counter; asynchronous to clk.
- sample_req  input  1  request to capture a stable count; level, sampled on each rising edge.
- count_out  output  WIDTH  last stable captured count; held between captures.
- count_valid  output  1  one-cycle pulse when count_out has been updated.
- tc_pulse  output  1  one-cycle pulse, coincident with count_valid, when a wrap-around is detected.
- wrap_cnt  output  WRAP_W  number of detected wrap-arounds, modulo 2^WRAP_W.
- busy  output  1  high while in WAIT.
- err  output  1  one-cycle pulse when a request times out.

Behaviour:
- Reset (clr=1, asynchronous, independent of clk):
  - s1, s2, s3, count_out, last_cap, wrap_cnt and tries all become 0.
  - count_valid, tc_pulse, busy and err become 0; state becomes IDLE.
  - Reset asserted mid-WAIT aborts the request with no pulse.
  - After clr deasserts, the first edge is normal operation.
- Synchronizer: on every edge, s1<=q_in, s2<=s1, s3<=s2, running in all states.
  - stable = (s2 == s3).
  - A q_in change reaches s2 two edges later and s3 three edges later.
- FSM state IDLE:
  - busy=0.
  - If sample_req=1 at an edge, go to WAIT and set tries<=0.
- FSM state WAIT (busy=1), evaluated at each edge:
  - If stable: count_out<=s2, last_cap<=s2, count_valid<=1, state<=IDLE.
    - If s2 < last_cap (unsigned), also tc_pulse<=1 and wrap_cnt<=wrap_cnt+1 (wraps modulo 2^WRAP_W).
  - Else if tries == MAX_TRIES-1: err<=1, state<=IDLE; count_out and last_cap are unchanged.
  - Else: tries<=tries+1.
  - sample_req is ignored while in WAIT; no queueing.
- Latency:
  - Request seen at edge k; earliest count_valid is high after edge k+1, for one cycle.
  - Worst case, err is high after edge k+MAX_TRIES.
- Pulses: count_valid, tc_pulse and err are registered, last exactly one cycle, and default to 0 otherwise.
  - count_valid and err are never high together.
- Back-to-back requests: a request held high continuously re-enters WAIT on the edge where count_valid or err rises. This gives at most one capture every 2 cycles.
- Equal value: a capture equal to last_cap is not a wrap.
  - The first capture after reset compares against 0, so it is never a wrap.
- Width: tries is clog2(MAX_TRIES) bits; the comparison is unsigned over WIDTH bits.

Test Plan:
- Reset: apply clr=1 mid-simulation with q_in=4'hA and sample_req=1 -> count_out=0, wrap_cnt=0, busy=0, with no clk edge needed; after release, the first request captures 4'hA.
- Static capture: q_in=4'h5 held for ≥3 cycles, sample_req pulsed at edge k -> count_valid=1 and count_out=5 after edge k+1; tc_pulse=0, err=0.
- Settling ripple: q_in steps 4'h7->4'h6->4'h4->4'h0->4'h8 on consecutive cycles (ripple of 7->8) with a request issued at the first step -> busy stays high until s2==s3; the only capture is count_out=8, with no intermediate value.
- Wrap detect: capture 4'hE, then 4'hF, then 4'h1 -> tc_pulse only on the 4'h1 capture; wrap_cnt goes 0->1. A subsequent capture of 4'h1 -> no tc_pulse.
- Timeout: q_in toggles every cycle between 4'h3 and 4'hC, request issued at edge k -> err=1 after edge k+8, count_out unchanged, count_valid=0.
- Continuous request: sample_req tied high, q_in counting slowly (one step every 10 cycles) -> count_valid every 2 cycles, count_out monotonic, wrap_cnt increments once per 16 counts.
